arb_rr_oht: RTL and testbench

- Round-robin arbiter that generates the registered one-hot select (`oht`) for the one-hot multiplexer tree directly downstream of it.
- WIDTH requesters raise `req`. The arbiter grants exactly one of them and holds that grant until the downstream consumer accepts the transfer (`vld`/`rdy` handshake). Priority then rotates past the served requester.
- It also returns a per-requester acknowledge and a binary index of the grant, for use by other logic.

---
 rtl/arb_rr_oht_if.sv | 32 +++
 rtl/arb_rr_oht.sv | 115 +++++++++++
 tb/tb_arb_rr_oht.sv | 121 ++++++++++++
 3 files changed

// File: rtl/arb_rr_oht_if.sv
// Request/grant bundle between the round-robin arbiter (master) and
// the requesters plus downstream consumer (slave).
interface arb_rr_oht_if #(
    parameter int WIDTH = 32
);
    localparam int WIDTH_LOG = $clog2(WIDTH);

    logic [WIDTH-1:0]     req;
    logic [WIDTH-1:0]     oht;
    logic [WIDTH_LOG-1:0] idx;
    logic                 vld;
    logic                 rdy;
    logic [WIDTH-1:0]     ack;

    modport master (
        input  req,
        input  rdy,
        output oht,
        output idx,
        output vld,
        output ack
    );

    modport slave (
        output req,
        output rdy,
        input  oht,
        input  idx,
        input  vld,
        input  ack
    );
endinterface

// File: rtl/arb_rr_oht.sv
// Round-robin arbiter producing a registered one-hot mux select; the grant is
// held until vld&rdy, then priority rotates past the served requester.
//
//   state | meaning
//   IDLE  | no grant outstanding (gnt == 0)
//   BUSY  | gnt holds one requester, waiting for rdy
module arb_rr_oht #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    arb_rr_oht_if.master  bus
);
    localparam int WIDTH_LOG = $clog2(WIDTH);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [WIDTH-1:0]     gnt, gnt_nxt;
    logic [WIDTH_LOG-1:0] ptr, ptr_nxt;
    logic [WIDTH_LOG-1:0] idx;
    logic [WIDTH_LOG-1:0] idx_inc;
    logic                 vld;
    logic                 load;

    // First set bit of r searching upward from p, wrapping at WIDTH-1.
    function automatic logic [WIDTH-1:0] win(input logic [WIDTH-1:0] r,
                                             input logic [WIDTH_LOG-1:0] p);
        logic [WIDTH-1:0]   res;
        logic               found;
        logic [WIDTH_LOG:0] j;
        res   = '0;
        found = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            j = {1'b0, p} + (WIDTH_LOG+1)'(i);
            if (j >= (WIDTH_LOG+1)'(WIDTH)) begin
                j = j - (WIDTH_LOG+1)'(WIDTH);
            end
            if (!found && r[j[WIDTH_LOG-1:0]]) begin
                res[j[WIDTH_LOG-1:0]] = 1'b1;
                found = 1'b1;
            end
        end
        return res;
    endfunction

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (gnt[i]) begin
                idx = idx | WIDTH_LOG'(i);
            end
        end
    end

    // Explicit wrap so non-power-of-two widths never produce an out-of-range pointer.
    assign idx_inc = (idx == WIDTH_LOG'(WIDTH - 1)) ? '0 : idx + 1'b1;
    assign vld     = |gnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            gnt   <= gnt_nxt;
            ptr   <= ptr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_nxt   = gnt;
        ptr_nxt   = ptr;
        load      = 1'b0;
        case (state)
            IDLE: begin
                load = 1'b1;
                if (|bus.req) begin
                    gnt_nxt   = win(bus.req, ptr);
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.rdy) begin
                    load      = 1'b1;
                    ptr_nxt   = idx_inc;
                    gnt_nxt   = win(bus.req, idx_inc);
                    state_nxt = (|bus.req) ? BUSY : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
            end
        endcase
    end

    assign bus.oht = gnt;
    assign bus.idx = idx;
    assign bus.vld = vld;
    assign bus.ack = gnt & {WIDTH{vld & bus.rdy & rst_n}};

    a_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
    a_state:  assert property (@(posedge clk) disable iff (!rst_n) (state == BUSY) == vld);
    a_ack:    assert property (@(posedge clk) disable iff (!rst_n) (bus.ack & ~gnt) == '0);
    a_stable: assert property (@(posedge clk) disable iff (!rst_n)
                               (vld && !bus.rdy) |=> $stable(gnt));
    a_subset: assert property (@(posedge clk) disable iff (!rst_n)
                               load |-> ((gnt_nxt & ~bus.req) == '0));
endmodule

// File: tb/tb_arb_rr_oht.sv
// Directed bench for arb_rr_oht: a WIDTH=4 vector table covering reset,
// rotation, backpressure, wrap, sticky grant and mid-grant reset, plus a WIDTH=5 run.
module tb_arb_rr_oht;
    logic clk = 1'b0;
    logic rst_n4;
    logic rst_n5;

    always #5 clk = ~clk;

    arb_rr_oht_if #(.WIDTH(4)) bus4 ();
    arb_rr_oht_if #(.WIDTH(5)) bus5 ();

    arb_rr_oht #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n4), .bus(bus4.master));
    arb_rr_oht #(.WIDTH(5)) u_dut5 (.clk(clk), .rst_n(rst_n5), .bus(bus5.master));

    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        logic       rdy;
        logic [3:0] oht;
        logic [1:0] idx;
        logic       vld;
        logic [3:0] ack;
    } vec_t;

    localparam int NVEC = 29;
    vec_t tv [0:NVEC-1];

    int ncmp = 0;
    int nerr = 0;

    task automatic check(input string name, input int n,
                         input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s step %0d: got %h expected %h", name, n, act, exp);
        end
    endtask

    int exp5 [0:6];

    initial begin
        //         rst   req      rdy   oht      idx   vld   ack
        tv[0]  = '{1'b0, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
        tv[3]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010};
        tv[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        tv[5]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000};
        tv[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
        tv[7]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0010};
        // backpressure on grant 0100 while req toggles
        tv[8]  = '{1'b1, 4'b1111, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000};
        tv[9]  = '{1'b1, 4'b0000, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000};
        tv[10] = '{1'b1, 4'b1011, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000};
        tv[11] = '{1'b1, 4'b0001, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000};
        tv[12] = '{1'b1, 4'b1010, 1'b0, 4'b0100, 2'd2, 1'b1, 4'b0000};
        tv[13] = '{1'b1, 4'b1011, 1'b1, 4'b0100, 2'd2, 1'b1, 4'b0100};
        tv[14] = '{1'b1, 4'b1011, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000};
        tv[15] = '{1'b1, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
        tv[16] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        // sole requester 3 wraps and is re-granted
        tv[17] = '{1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[18] = '{1'b1, 4'b1000, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000};
        tv[19] = '{1'b1, 4'b0011, 1'b1, 4'b1000, 2'd3, 1'b1, 4'b1000};
        tv[20] = '{1'b1, 4'b0011, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
        // sticky grant, then reset mid-grant
        tv[21] = '{1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000};
        tv[22] = '{1'b1, 4'b0001, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000};
        tv[23] = '{1'b1, 4'b0000, 1'b0, 4'b0010, 2'd1, 1'b1, 4'b0000};
        tv[24] = '{1'b0, 4'b1111, 1'b1, 4'b0010, 2'd1, 1'b1, 4'b0000};
        tv[25] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 2'd0, 1'b0, 4'b0000};
        // ptr must be 0 after reset: 1001 resolves to 0001, not 1000
        tv[26] = '{1'b1, 4'b1001, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};
        tv[27] = '{1'b1, 4'b0000, 1'b1, 4'b0001, 2'd0, 1'b1, 4'b0001};
        tv[28] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 4'b0000};

        exp5 = '{0, 1, 2, 3, 4, 0, 1};

        rst_n4    = 1'b0;
        rst_n5    = 1'b0;
        bus4.req  = '0;
        bus4.rdy  = 1'b0;
        bus5.req  = '0;
        bus5.rdy  = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            rst_n4   = tv[i].rst_n;
            bus4.req = tv[i].req;
            bus4.rdy = tv[i].rdy;
            #1;
            check("oht4", i, 32'(bus4.oht), 32'(tv[i].oht));
            check("idx4", i, 32'(bus4.idx), 32'(tv[i].idx));
            check("vld4", i, 32'(bus4.vld), 32'(tv[i].vld));
            check("ack4", i, 32'(bus4.ack), 32'(tv[i].ack));
        end

        // WIDTH=5: full request rotation must wrap 4 -> 0
        @(negedge clk);
        bus5.req = 5'b11111;
        bus5.rdy = 1'b1;
        rst_n5   = 1'b1;
        #1;
        check("vld5_idle", 0, 32'(bus5.vld), 32'd0);
        for (int k = 0; k < 7; k++) begin
            logic [4:0] e_oht;
            @(negedge clk);
            #1;
            e_oht = 5'd1 << exp5[k];
            check("idx5", k, 32'(bus5.idx), 32'(exp5[k]));
            check("oht5", k, 32'(bus5.oht), 32'(e_oht));
            check("ack5", k, 32'(bus5.ack), 32'(e_oht));
        end

        $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
        $finish;
    end
endmodule
